hub75_rx: RTL and testbench

- Receive-side HUB75 capture block: samples the panel pins driven by the matrix driver (shift clock, LATCH, OE, ADDR, RGB0/RGB1) and rebuilds each latched line pair as pixel writes to a framebuffer write port.
- Used for loopback checking of the driver on the Tang Nano 9k and as the input stage for chained/re-driven panels.
- Runs entirely on the 27 MHz system clock; HUB75 inputs are treated as asynchronous.

---
 rtl/hub75_rx_if.sv | 12 +
 rtl/hub75_rx.sv | 200 ++++++++++++++++++++
 tb/tb_hub75_rx.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hub75_rx_if.sv
// Framebuffer pixel-write port produced by the HUB75 receiver.
// master drives pixel writes, slave is the framebuffer that accepts them.
interface hub75_rx_if;
    logic       wr_valid;
    logic       wr_ready;
    logic [4:0] wr_row;
    logic [5:0] wr_col;
    logic [2:0] wr_rgb;

    modport master (output wr_valid, wr_row, wr_col, wr_rgb, input wr_ready);
    modport slave  (input wr_valid, wr_row, wr_col, wr_rgb, output wr_ready);
endinterface

// File: rtl/hub75_rx.sv
// HUB75 receive-side capture: rebuilds latched line pairs as framebuffer pixel writes.
// Optional OE-low intensity measurement is enabled with `define HUB75_RX_OE_MEAS_EN.
module hub75_rx #(
    parameter int PIXEL_COLUMNS = 64,
    parameter int PIXEL_LINES   = 16,
    parameter int OE_CNT_W      = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                hub_clk,
    input  logic                hub_lat,
    input  logic                hub_oe,
    input  logic [3:0]          hub_addr,
    input  logic [2:0]          hub_rgb0,
    input  logic [2:0]          hub_rgb1,
    hub75_rx_if.master          wr,
    output logic                frame_done,
    output logic                len_err,
    output logic                overrun,
    output logic [OE_CNT_W-1:0] oe_low_cnt
);

    localparam int SH_W = PIXEL_COLUMNS * 6;
    localparam int B_CLK = 10;
    localparam int B_LAT = 11;
    localparam int B_OE  = 12;
    // Packed as {oe, lat, clk, addr, rgb1, rgb0}; idle levels clk=1, lat=0, oe=1.
    localparam logic [12:0] SYNC_PRESET = 13'b1_0_1_0000_000_000;
    localparam logic [5:0]  COL_LAST    = 6'(PIXEL_COLUMNS - 1);

    typedef enum logic [1:0] {IDLE, TOP, BOT} state_t;

    logic [12:0]     s1_q, s2_q, s3_q;
    logic            clk_rise_q, lat_rise_q;
    logic [SH_W-1:0] sh_q, sh_next, line_q;
    logic [6:0]      cnt_q, cnt_next;
    logic [3:0]      addr_q;
    logic [5:0]      col_q, col_n;
    state_t          state_q, state_n;
    logic            armed_q, frame_q, frame_n;
    logic            len_err_q, overrun_q;
    logic            commit, valid, xfer;
    logic [5:0]      ent;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_q       <= SYNC_PRESET;
            s2_q       <= SYNC_PRESET;
            s3_q       <= SYNC_PRESET;
            clk_rise_q <= 1'b0;
            lat_rise_q <= 1'b0;
        end else begin
            s1_q       <= {hub_oe, hub_lat, hub_clk, hub_addr, hub_rgb1, hub_rgb0};
            s2_q       <= s1_q;
            s3_q       <= s2_q;
            clk_rise_q <= s2_q[B_CLK] & ~s3_q[B_CLK];
            lat_rise_q <= s2_q[B_LAT] & ~s3_q[B_LAT];
        end
    end

    // Edge pulses are registered, so s3_q holds the data that was current at the edge.
    always_comb begin
        sh_next  = sh_q;
        cnt_next = cnt_q;
        if (clk_rise_q) begin
            sh_next = {sh_q[SH_W-7:0], s3_q[5:0]};
            if (cnt_q != 7'd127)
                cnt_next = cnt_q + 7'd1;
        end
    end

    assign commit = lat_rise_q && (state_q == IDLE);

    always_ff @(posedge clk) begin
        sh_q <= sh_next;
        if (commit)
            line_q <= sh_next;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q     <= '0;
            len_err_q <= 1'b0;
            overrun_q <= 1'b0;
            addr_q    <= '0;
        end else if (lat_rise_q) begin
            cnt_q <= '0;
            if (cnt_next != 7'(PIXEL_COLUMNS))
                len_err_q <= 1'b1;
            if (state_q != IDLE)
                overrun_q <= 1'b1;
            if (commit)
                addr_q <= s3_q[9:6];
        end else begin
            cnt_q <= cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            col_q   <= '0;
            armed_q <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_n;
            col_q   <= col_n;
            armed_q <= (state_q != IDLE);
            frame_q <= frame_n;
        end
    end

    // armed_q delays wr_valid by one cycle after the commit that leaves IDLE.
    assign valid = armed_q && (state_q != IDLE);
    assign xfer  = valid && wr.wr_ready;

    always_comb begin
        state_n = state_q;
        col_n   = col_q;
        frame_n = 1'b0;
        case (state_q)
            IDLE: begin
                if (commit) begin
                    state_n = TOP;
                    col_n   = '0;
                end
            end
            TOP: begin
                if (xfer) begin
                    if (col_q == COL_LAST) begin
                        state_n = BOT;
                        col_n   = '0;
                    end else begin
                        col_n = col_q + 6'd1;
                    end
                end
            end
            BOT: begin
                if (xfer) begin
                    if (col_q == COL_LAST) begin
                        state_n = IDLE;
                        col_n   = '0;
                        frame_n = (addr_q == 4'(PIXEL_LINES - 1));
                    end else begin
                        col_n = col_q + 6'd1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                col_n   = '0;
            end
        endcase
    end

    assign ent = line_q[int'(col_q) * 6 +: 6];

    always_comb begin
        wr.wr_valid = valid;
        wr.wr_row   = '0;
        wr.wr_col   = '0;
        wr.wr_rgb   = '0;
        if (valid) begin
            wr.wr_col = col_q;
            if (state_q == TOP) begin
                wr.wr_row = {1'b0, addr_q};
                wr.wr_rgb = ent[2:0];
            end else begin
                wr.wr_row = {1'b0, addr_q} + 5'(PIXEL_LINES);
                wr.wr_rgb = ent[5:3];
            end
        end
    end

    assign frame_done = frame_q;
    assign len_err    = len_err_q;
    assign overrun    = overrun_q;

`ifdef HUB75_RX_OE_MEAS_EN
    logic [OE_CNT_W-1:0] oe_cnt_q, oe_low_q;

    // Restarts on every latch edge, accepted or dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            oe_cnt_q <= '0;
            oe_low_q <= '0;
        end else if (lat_rise_q) begin
            oe_low_q <= oe_cnt_q;
            oe_cnt_q <= '0;
        end else if (!s2_q[B_OE] && (oe_cnt_q != {OE_CNT_W{1'b1}})) begin
            oe_cnt_q <= oe_cnt_q + 1'b1;
        end
    end

    assign oe_low_cnt = oe_low_q;
`else
    assign oe_low_cnt = '0;
`endif

endmodule

// File: tb/tb_hub75_rx.sv
// Self-checking bench for hub75_rx: vector table of line transfers plus hand sequences
// for overrun, length error, OE measurement and reset mid-drain, with a write scoreboard.
module tb_hub75_rx;

    localparam int COLS  = 64;
    localparam int LINES = 16;

    typedef struct packed {
        logic [4:0] row;
        logic [5:0] col;
        logic [2:0] rgb;
    } wr_t;

    typedef struct {
        logic [3:0] addr;
        int         pattern;
        int         nshift;
        int         ready_mode;
        logic       exp_len_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        hub_clk = 1'b1;
    logic        hub_lat = 1'b0;
    logic        hub_oe = 1'b1;
    logic [3:0]  hub_addr = '0;
    logic [2:0]  hub_rgb0 = '0;
    logic [2:0]  hub_rgb1 = '0;
    logic        frame_done, len_err, overrun;
    logic [15:0] oe_low_cnt;

    hub75_rx_if wr_bus ();

    hub75_rx #(.PIXEL_COLUMNS(COLS), .PIXEL_LINES(LINES), .OE_CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .hub_clk    (hub_clk),
        .hub_lat    (hub_lat),
        .hub_oe     (hub_oe),
        .hub_addr   (hub_addr),
        .hub_rgb0   (hub_rgb0),
        .hub_rgb1   (hub_rgb1),
        .wr         (wr_bus),
        .frame_done (frame_done),
        .len_err    (len_err),
        .overrun    (overrun),
        .oe_low_cnt (oe_low_cnt)
    );

    always #5 clk = ~clk;

    wr_t        exp_q[$];
    logic [5:0] model_sh [COLS];
    int         total = 0;
    int         bad = 0;
    int         ready_mode = 1;
    int         frame_cnt = 0;
    int         exp_frames = 0;
    int         write_cnt = 0;
    logic [4:0] last_row = '0;
    logic [5:0] last_col = '0;
    vec_t       vecs [4];

    task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor: ready is set first, then the transfer for the next edge is judged.
    initial begin
        logic stall_prev;
        wr_t  held;
        wr_t  e;
        stall_prev = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            case (ready_mode)
                0:       wr_bus.wr_ready = 1'b0;
                1:       wr_bus.wr_ready = 1'b1;
                default: wr_bus.wr_ready = 1'($urandom_range(0, 1));
            endcase
            if (stall_prev) begin
                check_output("stall_valid", 32'(wr_bus.wr_valid), 32'd1);
                check_output("stall_hold", 32'({wr_bus.wr_row, wr_bus.wr_col, wr_bus.wr_rgb}), 32'(held));
            end
            if (frame_done) begin
                frame_cnt++;
                check_output("frame_pos", 32'({last_row, last_col}), 32'({5'd31, 6'd63}));
            end
            if (wr_bus.wr_valid && wr_bus.wr_ready) begin
                write_cnt++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_write: got row %0d col %0d, required no write",
                             wr_bus.wr_row, wr_bus.wr_col);
                end else begin
                    e = exp_q.pop_front();
                    check_output("wr_row", 32'(wr_bus.wr_row), 32'(e.row));
                    check_output("wr_col", 32'(wr_bus.wr_col), 32'(e.col));
                    check_output("wr_rgb", 32'(wr_bus.wr_rgb), 32'(e.rgb));
                end
                last_row = wr_bus.wr_row;
                last_col = wr_bus.wr_col;
            end
            stall_prev = wr_bus.wr_valid && !wr_bus.wr_ready;
            held = {wr_bus.wr_row, wr_bus.wr_col, wr_bus.wr_rgb};
        end
    end

    function automatic logic [5:0] pix(int pattern, int i, int n);
        logic [31:0] r;
        case (pattern)
            0:       pix = (i == n - 1) ? 6'b000_001 : 6'b000_000;
            1:       pix = {3'(i), 3'b000};
            default: begin
                r = $urandom;
                pix = r[5:0];
            end
        endcase
    endfunction

    task automatic shift_pixel(logic [5:0] px);
        hub_rgb0 = px[2:0];
        hub_rgb1 = px[5:3];
        hub_clk  = 1'b0;
        repeat (4) @(negedge clk);
        hub_clk = 1'b1;
        for (int i = COLS - 1; i > 0; i--)
            model_sh[i] = model_sh[i - 1];
        model_sh[0] = px;
        repeat (4) @(negedge clk);
    endtask

    task automatic latch_line(logic [3:0] a, bit commit);
        int first;
        hub_addr = a;
        repeat (4) @(negedge clk);
        if (commit) begin
            for (int c = 0; c < COLS; c++)
                exp_q.push_back({5'(a), 6'(c), model_sh[c][2:0]});
            for (int c = 0; c < COLS; c++)
                exp_q.push_back({5'(a) + 5'd16, 6'(c), model_sh[c][5:3]});
            if (a == 4'd15)
                exp_frames++;
        end
        hub_lat = 1'b1;
        first = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (first == 0 && wr_bus.wr_valid)
                first = k;
        end
        if (commit)
            check_output("latch_latency", 32'(first), 32'd5);
        hub_lat = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_drain(string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || wr_bus.wr_valid) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_output(name, 32'(exp_q.size()), 32'd0);
        repeat (4) @(negedge clk);
    endtask

    task automatic apply_stimulus(vec_t v);
        ready_mode = v.ready_mode;
        for (int i = 0; i < v.nshift; i++)
            shift_pixel(pix(v.pattern, i, v.nshift));
        latch_line(v.addr, 1'b1);
    endtask

    initial begin
        int oe_val;
        vecs[0] = '{addr: 4'd0,  pattern: 0, nshift: 64, ready_mode: 1, exp_len_err: 1'b0};
        vecs[1] = '{addr: 4'd15, pattern: 1, nshift: 64, ready_mode: 1, exp_len_err: 1'b0};
        vecs[2] = '{addr: 4'd5,  pattern: 2, nshift: 64, ready_mode: 2, exp_len_err: 1'b0};
        vecs[3] = '{addr: 4'd15, pattern: 2, nshift: 64, ready_mode: 2, exp_len_err: 1'b0};
        wr_bus.wr_ready = 1'b1;
        for (int i = 0; i < COLS; i++)
            model_sh[i] = '0;

        rst = 1'b0;
        repeat (5) @(negedge clk);
        check_output("rst_wr_valid", 32'(wr_bus.wr_valid), 32'd0);
        check_output("rst_wr_row", 32'(wr_bus.wr_row), 32'd0);
        check_output("rst_wr_col", 32'(wr_bus.wr_col), 32'd0);
        check_output("rst_wr_rgb", 32'(wr_bus.wr_rgb), 32'd0);
        check_output("rst_frame_done", 32'(frame_done), 32'd0);
        check_output("rst_len_err", 32'(len_err), 32'd0);
        check_output("rst_overrun", 32'(overrun), 32'd0);
        check_output("rst_oe_low_cnt", 32'(oe_low_cnt), 32'd0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            frame_cnt  = 0;
            exp_frames = 0;
            write_cnt  = 0;
            apply_stimulus(vecs[v]);
            wait_drain("vec_drain");
            check_output("vec_write_cnt", 32'(write_cnt), 32'd128);
            check_output("vec_len_err", 32'(len_err), 32'(vecs[v].exp_len_err));
            check_output("vec_overrun", 32'(overrun), 32'd0);
            check_output("vec_frames", 32'(frame_cnt), 32'(exp_frames));
        end

        $display("[TB] short line (63 shifts)");
        ready_mode = 1;
        write_cnt = 0;
        for (int i = 0; i < 63; i++)
            shift_pixel(pix(2, i, 63));
        latch_line(4'd2, 1'b1);
        wait_drain("short_drain");
        check_output("short_len_err", 32'(len_err), 32'd1);
        check_output("short_overrun", 32'(overrun), 32'd0);
        check_output("short_write_cnt", 32'(write_cnt), 32'd128);

        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_output("rst2_len_err", 32'(len_err), 32'd0);
        check_output("rst2_overrun", 32'(overrun), 32'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        $display("[TB] overrun while stalled");
        ready_mode = 0;
        for (int i = 0; i < 64; i++)
            shift_pixel(pix(2, i, 64));
        write_cnt = 0;
        latch_line(4'd7, 1'b1);
        hub_addr = 4'd9;
        hub_lat  = 1'b1;
        repeat (4) @(negedge clk);
        hub_lat = 1'b0;
        repeat (4) @(negedge clk);
        check_output("ovr_flag", 32'(overrun), 32'd1);
        check_output("ovr_still_valid", 32'(wr_bus.wr_valid), 32'd1);
        ready_mode = 1;
        wait_drain("ovr_drain");
        check_output("ovr_write_cnt", 32'(write_cnt), 32'd128);

        $display("[TB] OE low measurement");
        latch_line(4'd3, 1'b1);
        wait_drain("oe_drain1");
        hub_oe = 1'b0;
        repeat (500) @(negedge clk);
        hub_oe = 1'b1;
        repeat (5) @(negedge clk);
        latch_line(4'd3, 1'b1);
        repeat (2) @(negedge clk);
        oe_val = int'(oe_low_cnt);
`ifdef HUB75_RX_OE_MEAS_EN
        total++;
        if (oe_val < 498 || oe_val > 502) begin
            bad++;
            $display("[TB] FAIL oe_low_cnt: got %0d required 498..502", oe_val);
        end
`else
        check_output("oe_low_cnt", 32'(oe_val), 32'd0);
`endif
        wait_drain("oe_drain2");

        $display("[TB] reset mid-drain");
        for (int i = 0; i < 64; i++)
            shift_pixel(pix(2, i, 64));
        latch_line(4'd15, 1'b1);
        repeat (20) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        @(negedge clk);
        check_output("mid_rst_valid", 32'(wr_bus.wr_valid), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        write_cnt = 0;
        frame_cnt = 0;
        repeat (300) @(negedge clk);
        check_output("mid_rst_writes", 32'(write_cnt), 32'd0);
        check_output("mid_rst_frames", 32'(frame_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

endmodule
